// File: rtl/local_move_controller_pkg.sv
// Shared types and helpers for the local-move controllers.
package local_move_controller_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPropose,
    StSelect,
    StDone
  } state_e;

  // Widest mask the helpers can build; callers slice down to their own width.
  localparam int unsigned MaskMaxWidth = 32;

  // A clause count needs one bit more than an index so that the full count fits.
  function automatic int unsigned clause_count_width(input int unsigned idx_width);
    return idx_width + 1;
  endfunction

  // Bit k set when k < count.
  function automatic logic [MaskMaxWidth-1:0] thermometer_mask(input int unsigned count);
    return ~({MaskMaxWidth{1'b1}} << count);
  endfunction

  function automatic logic [MaskMaxWidth-1:0] one_hot(input int unsigned idx);
    return MaskMaxWidth'(1) << idx;
  endfunction

endpackage

// File: rtl/local_move_controller_if.sv
// Handshake and datapath-control bundle between the search FSM, controller and datapath.
interface local_move_controller_if #(
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 2,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1
);
  import local_move_controller_pkg::*;

  localparam int unsigned IdxWidth    = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int unsigned ClauseCount = 1 << MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int unsigned CountWidth  = clause_count_width(MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX);
  localparam int unsigned BoolCount   = 1 << MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX;
  localparam int unsigned IntCount    = 1 << MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX;

  logic                   in_start;
  logic                   in_load_formula;
  logic [CountWidth-1:0]  in_number_of_clauses;
  logic [BoolCount-1:0]   in_boolean_active_mask;
  logic [IntCount-1:0]    in_integer_active_mask;
  logic                   in_datapath_done;
  logic [IdxWidth-1:0]    out_clause_read_index;
  logic [IdxWidth-1:0]    out_clause_index;
  logic [ClauseCount-1:0] out_clauses_write_enable;
  logic [ClauseCount-1:0] out_clauses_enable;
  logic [BoolCount-1:0]   out_boolean_propose_enable;
  logic [IntCount-1:0]    out_integer_propose_enable;
  logic                   out_find_best_gain_enable;
  logic                   out_busy;
  logic                   out_done;
  logic                   out_best_found;

  // Controller side.
  modport master (
    input  in_start, in_load_formula, in_number_of_clauses, in_boolean_active_mask,
           in_integer_active_mask, in_datapath_done,
    output out_clause_read_index, out_clause_index, out_clauses_write_enable,
           out_clauses_enable, out_boolean_propose_enable, out_integer_propose_enable,
           out_find_best_gain_enable, out_busy, out_done, out_best_found
  );

  // Search FSM / datapath side.
  modport slave (
    output in_start, in_load_formula, in_number_of_clauses, in_boolean_active_mask,
           in_integer_active_mask, in_datapath_done,
    input  out_clause_read_index, out_clause_index, out_clauses_write_enable,
           out_clauses_enable, out_boolean_propose_enable, out_integer_propose_enable,
           out_find_best_gain_enable, out_busy, out_done, out_best_found
  );

endinterface

// File: rtl/local_move_controller_clause_load_sequencer.sv
// Streams clause addresses 0..N-1 and trails each read by one cycle with its write strobe.
module local_move_controller_clause_load_sequencer
  import local_move_controller_pkg::*;
#(
  parameter int unsigned IdxWidth = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [IdxWidth:0]             count_i,
  output logic [IdxWidth-1:0]           read_index_o,
  output logic [IdxWidth-1:0]           write_index_o,
  output logic [(1 << IdxWidth)-1:0]    write_enable_o,
  output logic                          last_o
);

  localparam int unsigned ClauseCount = 1 << IdxWidth;
  localparam logic [IdxWidth:0] CountOne = (IdxWidth + 1)'(1);

  logic                   rd_valid_q, rd_valid_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [IdxWidth-1:0]    rd_q, rd_d;
  logic [IdxWidth-1:0]    wr_idx_q, wr_idx_d;
  logic [IdxWidth:0]      n_q, n_d;
  logic [ClauseCount-1:0] wr_en_q, wr_en_d;
  logic [MaskMaxWidth-1:0] oh;
  logic                   rd_last;

  // Next read address and the write stage fed from the read issued last cycle.
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_d       = rd_q;
    n_d        = n_q;
    wr_valid_d = 1'b0;
    wr_idx_d   = '0;
    wr_en_d    = '0;
    oh         = one_hot(32'(rd_q));
    rd_last    = ({1'b0, rd_q} == (n_q - CountOne));
    if (start_i) begin
      rd_valid_d = 1'b1;
      rd_d       = '0;
      n_d        = count_i;
    end else if (rd_valid_q) begin
      wr_valid_d = 1'b1;
      wr_idx_d   = rd_q;
      wr_en_d    = oh[ClauseCount-1:0];
      if (rd_last) begin
        rd_valid_d = 1'b0;
        rd_d       = '0;
      end else begin
        rd_d = rd_q + IdxWidth'(1);
      end
    end
  end

  // Read counter and write pipeline registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_q       <= '0;
      wr_idx_q   <= '0;
      n_q        <= '0;
      wr_en_q    <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      rd_q       <= rd_d;
      wr_idx_q   <= wr_idx_d;
      n_q        <= n_d;
      wr_en_q    <= wr_en_d;
    end
  end

  assign read_index_o   = rd_q;
  assign write_index_o  = wr_idx_q;
  assign write_enable_o = wr_en_q;
  // Final write in flight with no read behind it.
  assign last_o         = wr_valid_q & ~rd_valid_q;

endmodule

// File: rtl/local_move_controller.sv
// Sequencer: clause load, then propose, then best-gain selection, then a done pulse.
module local_move_controller
  import local_move_controller_pkg::*;
#(
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 2,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
  parameter int unsigned PROPOSE_CYCLES                              = 2,
  parameter int unsigned SELECT_TIMEOUT                              = 4
) (
  input logic                     in_clk,
  input logic                     in_reset,
  local_move_controller_if.master bus
);

  localparam int unsigned ClauseCount = 1 << MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int unsigned CountWidth  = clause_count_width(MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX);
  localparam int unsigned BoolCount   = 1 << MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX;
  localparam int unsigned IntCount    = 1 << MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX;
  localparam int unsigned TimerMax    = (PROPOSE_CYCLES > SELECT_TIMEOUT) ? PROPOSE_CYCLES
                                                                          : SELECT_TIMEOUT;
  localparam int unsigned TimerWidth  = $clog2(TimerMax) + 1;

  localparam logic [CountWidth-1:0] CountMax    = CountWidth'(ClauseCount);
  localparam logic [TimerWidth-1:0] ProposeLast = TimerWidth'(PROPOSE_CYCLES - 1);
  localparam logic [TimerWidth-1:0] SelectLast  = TimerWidth'(SELECT_TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [TimerWidth-1:0]   timer_q, timer_d;
  logic [BoolCount-1:0]    bool_mask_q, bool_mask_d;
  logic [IntCount-1:0]     int_mask_q, int_mask_d;
  logic [ClauseCount-1:0]  clauses_en_q, clauses_en_d;
  logic [CountWidth-1:0]   count_sat;
  logic [MaskMaxWidth-1:0] therm;
  logic                    found_d;
  logic                    seq_start;
  logic                    seq_last;

  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    best_found_q, best_found_d;
  logic                    fbg_en_q, fbg_en_d;
  logic [BoolCount-1:0]    bool_prop_q, bool_prop_d;
  logic [IntCount-1:0]     int_prop_q, int_prop_d;

  assign count_sat = (bus.in_number_of_clauses > CountMax) ? CountMax : bus.in_number_of_clauses;
  assign therm     = thermometer_mask(32'(count_sat));

  // State register plus the per-operation latches and stage timer.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      bool_mask_q  <= '0;
      int_mask_q   <= '0;
      clauses_en_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bool_mask_q  <= bool_mask_d;
      int_mask_q   <= int_mask_d;
      clauses_en_q <= clauses_en_d;
    end
  end

  // Next-state: stage transitions, start latching and stage timer.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + TimerWidth'(1);
    bool_mask_d  = bool_mask_q;
    int_mask_d   = int_mask_q;
    clauses_en_d = clauses_en_q;
    found_d      = 1'b0;
    seq_start    = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (bus.in_start) begin
          bool_mask_d  = bus.in_boolean_active_mask;
          int_mask_d   = bus.in_integer_active_mask;
          clauses_en_d = therm[ClauseCount-1:0];
          if (bus.in_load_formula && (count_sat != '0)) begin
            state_d   = StLoad;
            seq_start = 1'b1;
          end else begin
            state_d = StPropose;
          end
        end
      end
      StLoad: begin
        timer_d = '0;
        if (seq_last) state_d = StPropose;
      end
      StPropose: begin
        if (timer_q == ProposeLast) begin
          state_d = StSelect;
          timer_d = '0;
        end
      end
      StSelect: begin
        // Datapath done wins over a timeout landing in the same cycle.
        if (bus.in_datapath_done) begin
          state_d = StDone;
          found_d = 1'b1;
        end else if (timer_q == SelectLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        timer_d = '0;
        state_d = StIdle;
      end
      default: begin
        timer_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Output next values decoded from the upcoming state so every output is a flop.
  always_comb begin
    busy_d       = (state_d != StIdle);
    done_d       = (state_d == StDone);
    best_found_d = found_d;
    fbg_en_d     = (state_d == StSelect);
    bool_prop_d  = (state_d == StPropose) ? bool_mask_d : '0;
    int_prop_d   = (state_d == StPropose) ? int_mask_d : '0;
  end

  // Output registers.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_found_q <= 1'b0;
      fbg_en_q     <= 1'b0;
      bool_prop_q  <= '0;
      int_prop_q   <= '0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      best_found_q <= best_found_d;
      fbg_en_q     <= fbg_en_d;
      bool_prop_q  <= bool_prop_d;
      int_prop_q   <= int_prop_d;
    end
  end

  local_move_controller_clause_load_sequencer #(
    .IdxWidth(MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)
  ) u_clause_load_sequencer (
    .clk_i          (in_clk),
    .rst_i          (in_reset),
    .start_i        (seq_start),
    .count_i        (count_sat),
    .read_index_o   (bus.out_clause_read_index),
    .write_index_o  (bus.out_clause_index),
    .write_enable_o (bus.out_clauses_write_enable),
    .last_o         (seq_last)
  );

  assign bus.out_clauses_enable         = clauses_en_q;
  assign bus.out_boolean_propose_enable = bool_prop_q;
  assign bus.out_integer_propose_enable = int_prop_q;
  assign bus.out_find_best_gain_enable  = fbg_en_q;
  assign bus.out_busy                   = busy_q;
  assign bus.out_done                   = done_q;
  assign bus.out_best_found             = best_found_q;

endmodule
